// File: rtl/pipeline_id_idex.sv
// pipeline_id_idex
//   Instruction-decode stage plus the ID/EX pipeline register of the 5-stage
//   MIPS core. Decodes the IF/ID word, drives the register-file read ports,
//   detects load-use and jump-register hazards, resolves branches reported by
//   EX and returns next-PC / fetch-hold / flush control to the fetch stage.
//
// Ports
//   clk, reset            : clock, asynchronous active-low reset
//   IFID[63:0]            : {PC+4, instruction} from fetch
//   ALUOut                : branch condition for the instruction in ID/EX
//   MEM_RegWrite, MEM_Rd  : destination of the instruction in EX/MEM
//   rs_addr, rt_addr      : register-file read addresses
//   rs_data, rt_data      : register-file read data (WB bypassed internally)
//   PCSrc, JT, DatabusA   : next-PC select and jump targets (combinational)
//   ConBA                 : registered branch target of the ID/EX instruction
//   PCWrite, IFIDWrite    : 0 = hold PC / hold IF/ID
//   Stall                 : 1 = IF/ID loads a NOP
//   ex_*                  : registered ID/EX bundle
//
// Next-PC / hold / flush outputs are purely combinational; the only state is
// the ID/EX bundle and ConBA, so there is no FSM to expose. There is no
// valid/ready handshake: PCWrite/IFIDWrite are hold requests that fetch must
// obey in the same cycle, and a bubble in ID/EX is encoded as all-zero fields.
module pipeline_id_idex #(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] IFID,
    input  logic        ALUOut,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  MEM_Rd,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [2:0]  PCSrc,
    output logic [25:0] JT,
    output logic [31:0] DatabusA,
    output logic [31:0] ConBA,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        Stall,
    output logic [31:0] ex_pc4,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_shamt,
    output logic [3:0]  ex_aluop,
    output logic        ex_alusrc,
    output logic [1:0]  ex_regdst,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic [1:0]  ex_memtoreg,
    output logic        ex_regwrite,
    output logic        ex_branch
);

    logic [31:0] pc4;
    logic [5:0]  op;
    logic [5:0]  fn;

    assign pc4      = IFID[63:32];
    assign op       = IFID[31:26];
    assign fn       = IFID[5:0];
    assign rs_addr  = IFID[25:21];
    assign rt_addr  = IFID[20:16];
    assign JT       = IFID[25:0];
    assign DatabusA = rs_data;

    // Decoded controls for the instruction currently in ID
    logic [3:0]  d_aluop;
    logic        d_alusrc;
    logic [1:0]  d_regdst;
    logic        d_memread;
    logic        d_memwrite;
    logic [1:0]  d_memtoreg;
    logic        d_regwrite;
    logic        d_branch;
    logic        d_zext;
    logic        d_reads_rt;
    logic        d_is_j;
    logic        d_is_jr;

    always_comb begin
        d_aluop    = 4'd0;
        d_alusrc   = 1'b0;
        d_regdst   = 2'd0;
        d_memread  = 1'b0;
        d_memwrite = 1'b0;
        d_memtoreg = 2'd0;
        d_regwrite = 1'b0;
        d_branch   = 1'b0;
        d_zext     = 1'b0;
        d_reads_rt = 1'b0;
        d_is_j     = 1'b0;
        d_is_jr    = 1'b0;
        case (op)
            6'h00: begin
                d_reads_rt = 1'b1;
                d_regdst   = 2'd1;
                d_regwrite = 1'b1;
                case (fn)
                    6'h20, 6'h21: d_aluop = 4'd0;   // add, addu
                    6'h22, 6'h23: d_aluop = 4'd1;   // sub, subu
                    6'h24:        d_aluop = 4'd2;   // and
                    6'h25:        d_aluop = 4'd3;   // or
                    6'h26:        d_aluop = 4'd4;   // xor
                    6'h27:        d_aluop = 4'd5;   // nor
                    6'h2A:        d_aluop = 4'd6;   // slt
                    6'h2B:        d_aluop = 4'd7;   // sltu
                    6'h00:        d_aluop = 4'd8;   // sll
                    6'h02:        d_aluop = 4'd9;   // srl
                    6'h03:        d_aluop = 4'd10;  // sra
                    6'h08: begin                    // jr
                        d_regdst   = 2'd0;
                        d_regwrite = 1'b0;
                        d_is_jr    = 1'b1;
                    end
                    6'h09: begin                    // jalr: rd <= pc4
                        d_memtoreg = 2'd2;
                        d_is_jr    = 1'b1;
                    end
                    default: begin
                        d_regdst   = 2'd0;
                        d_regwrite = 1'b0;
                    end
                endcase
            end
            6'h23: begin                            // lw
                d_alusrc = 1'b1; d_memread = 1'b1; d_memtoreg = 2'd1; d_regwrite = 1'b1;
            end
            6'h2B: begin                            // sw
                d_alusrc = 1'b1; d_memwrite = 1'b1; d_reads_rt = 1'b1;
            end
            6'h0F: begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_aluop = 4'd11; end // lui
            6'h08,
            6'h09: begin d_alusrc = 1'b1; d_regwrite = 1'b1; end                  // addi(u)
            6'h0C: begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_aluop = 4'd2; d_zext = 1'b1; end
            6'h0D: begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_aluop = 4'd3; d_zext = 1'b1; end
            6'h0A: begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_aluop = 4'd6; end  // slti
            6'h0B: begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_aluop = 4'd7; end  // sltiu
            6'h04: begin d_branch = 1'b1; d_reads_rt = 1'b1; d_aluop = 4'd12; end // beq
            6'h05: begin d_branch = 1'b1; d_reads_rt = 1'b1; d_aluop = 4'd13; end // bne
            6'h02: d_is_j = 1'b1;                                                 // j
            6'h03: begin                                                          // jal
                d_is_j = 1'b1; d_regdst = 2'd2; d_memtoreg = 2'd2; d_regwrite = 1'b1;
            end
            default: ;                              // unknown encodings behave as NOP
        endcase
    end

    logic [31:0] imm_ext;
    logic [31:0] conba_next;
    logic [4:0]  d_dest;
    logic [4:0]  ex_dest;

    assign imm_ext    = d_zext ? {16'h0000, IFID[15:0]} : {{16{IFID[15]}}, IFID[15:0]};
    assign conba_next = pc4 + {imm_ext[29:0], 2'b00};

    always_comb begin
        case (d_regdst)
            2'd0:    d_dest = rt_addr;
            2'd1:    d_dest = IFID[15:11];
            default: d_dest = RA_REG;
        endcase
        case (ex_regdst)
            2'd0:    ex_dest = ex_rt;
            2'd1:    ex_dest = ex_rd;
            default: ex_dest = RA_REG;
        endcase
    end

    // ex_regwrite is already 0 whenever the ID/EX destination is $0, so a
    // nonzero rs_addr is enough to keep $0 from ever matching.
    logic branch_taken;
    logic load_use;
    logic jr_hazard;
    logic load_bubble;

    assign branch_taken = ex_branch & ALUOut;
    assign load_use     = ex_memread && (ex_rt != 5'd0) &&
                          ((ex_rt == rs_addr) || (d_reads_rt && (ex_rt == rt_addr)));
    assign jr_hazard    = d_is_jr && (rs_addr != 5'd0) &&
                          ((ex_regwrite && (ex_dest == rs_addr)) ||
                           (MEM_RegWrite && (MEM_Rd == rs_addr)));

    always_comb begin
        PCSrc       = 3'b000;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        Stall       = 1'b0;
        load_bubble = 1'b0;
        if (branch_taken) begin
            PCSrc       = 3'b001;
            Stall       = 1'b1;
            load_bubble = 1'b1;
        end else if (load_use || jr_hazard) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            load_bubble = 1'b1;
        end else if (d_is_j) begin
            PCSrc = 3'b010;
            Stall = 1'b1;
        end else if (d_is_jr) begin
            PCSrc = 3'b011;
            Stall = 1'b1;
        end
    end

    // A bubble is the all-zero bundle, identical to the reset value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || load_bubble) begin
            ex_pc4 <= '0; ex_rs_data <= '0; ex_rt_data <= '0; ex_imm <= '0; ConBA <= '0;
            ex_rs <= '0; ex_rt <= '0; ex_rd <= '0; ex_shamt <= '0;
            ex_aluop <= '0; ex_alusrc <= 1'b0; ex_regdst <= '0;
            ex_memread <= 1'b0; ex_memwrite <= 1'b0; ex_memtoreg <= '0;
            ex_regwrite <= 1'b0; ex_branch <= 1'b0;
        end else begin
            ex_pc4      <= pc4;
            ex_rs_data  <= rs_data;
            ex_rt_data  <= rt_data;
            ex_imm      <= imm_ext;
            ConBA       <= conba_next;
            ex_rs       <= rs_addr;
            ex_rt       <= rt_addr;
            ex_rd       <= IFID[15:11];
            ex_shamt    <= IFID[10:6];
            ex_aluop    <= d_aluop;
            ex_alusrc   <= d_alusrc;
            ex_regdst   <= d_regdst;
            ex_memread  <= d_memread;
            ex_memwrite <= d_memwrite;
            ex_memtoreg <= d_memtoreg;
            ex_regwrite <= d_regwrite && (d_dest != 5'd0);
            ex_branch   <= d_branch;
        end
    end

endmodule

// File: tb/tb_pipeline_id_idex.sv
// tb_pipeline_id_idex
//   Drives instructions described by mnemonic through pipeline_id_idex and
//   compares every output against a mnemonic-level reference model.
module tb_pipeline_id_idex;

    typedef enum int {
        K_ADD, K_ADDU, K_SUB, K_SUBU, K_AND, K_OR, K_XOR, K_NOR, K_SLT, K_SLTU,
        K_SLL, K_SRL, K_SRA, K_JR, K_JALR,
        K_LW, K_SW, K_LUI, K_ADDI, K_ADDIU, K_ANDI, K_ORI, K_SLTI, K_SLTIU, K_BEQ, K_BNE,
        K_J, K_JAL, K_BAD
    } kind_e;
    localparam int N_KIND = 29;

    // Mnemonic properties: encoding and the control word it must produce
    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] alu;
        logic [1:0] dst;   // 0 rt, 1 rd, 2 link register
        logic       src;
        logic       mr;
        logic       mw;
        logic [1:0] m2r;
        logic       wr;
        logic       br;
    } info_t;

    // Expected ID/EX content; lvl selects what is meaningful to compare:
    // 0 bubble (controls+indices), 1 controls only, 2 +data, 3 +imm/ConBA
    typedef struct packed {
        logic [1:0]  lvl;
        logic [4:0]  dest;
        logic [31:0] pc4;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [31:0] conba;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [3:0]  alu;
        logic        src;
        logic [1:0]  dst;
        logic        mr;
        logic        mw;
        logic [1:0]  m2r;
        logic        wr;
        logic        br;
    } idex_t;
    localparam int IDEX_W = $bits(idex_t);

    logic        clk;
    logic        reset;
    logic [63:0] IFID;
    logic        ALUOut;
    logic        MEM_RegWrite;
    logic [4:0]  MEM_Rd;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic [2:0]  PCSrc;
    logic [25:0] JT;
    logic [31:0] DatabusA, ConBA;
    logic        PCWrite, IFIDWrite, Stall;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [3:0]  ex_aluop;
    logic        ex_alusrc;
    logic [1:0]  ex_regdst;
    logic        ex_memread, ex_memwrite;
    logic [1:0]  ex_memtoreg;
    logic        ex_regwrite, ex_branch;

    int n_checks = 0;
    int n_fail   = 0;
    logic [IDEX_W-1:0] exp_q[$];
    idex_t m_ex;

    pipeline_id_idex #(.RA_REG(5'd31)) dut (
        .clk(clk), .reset(reset), .IFID(IFID), .ALUOut(ALUOut),
        .MEM_RegWrite(MEM_RegWrite), .MEM_Rd(MEM_Rd),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .PCSrc(PCSrc), .JT(JT), .DatabusA(DatabusA), .ConBA(ConBA),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .Stall(Stall),
        .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_branch(ex_branch)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bundle(input string p, input idex_t e);
        check_eq({p, " ex_aluop"},    64'(ex_aluop),    64'(e.alu));
        check_eq({p, " ex_alusrc"},   64'(ex_alusrc),   64'(e.src));
        check_eq({p, " ex_regdst"},   64'(ex_regdst),   64'(e.dst));
        check_eq({p, " ex_memread"},  64'(ex_memread),  64'(e.mr));
        check_eq({p, " ex_memwrite"}, 64'(ex_memwrite), 64'(e.mw));
        check_eq({p, " ex_memtoreg"}, 64'(ex_memtoreg), 64'(e.m2r));
        check_eq({p, " ex_regwrite"}, 64'(ex_regwrite), 64'(e.wr));
        check_eq({p, " ex_branch"},   64'(ex_branch),   64'(e.br));
        if (e.lvl != 2'd1) begin
            check_eq({p, " ex_rs"},    64'(ex_rs),    64'(e.rs));
            check_eq({p, " ex_rt"},    64'(ex_rt),    64'(e.rt));
            check_eq({p, " ex_rd"},    64'(ex_rd),    64'(e.rd));
            check_eq({p, " ex_shamt"}, 64'(ex_shamt), 64'(e.sh));
        end
        if (e.lvl >= 2'd2) begin
            check_eq({p, " ex_pc4"},     64'(ex_pc4),     64'(e.pc4));
            check_eq({p, " ex_rs_data"}, 64'(ex_rs_data), 64'(e.rsd));
            check_eq({p, " ex_rt_data"}, 64'(ex_rt_data), 64'(e.rtd));
        end
        if (e.lvl == 2'd3) begin
            check_eq({p, " ex_imm"}, 64'(ex_imm), 64'(e.imm));
            check_eq({p, " ConBA"},  64'(ConBA),  64'(e.conba));
        end
    endtask

    // ---------------- reference model ----------------
    function automatic info_t mk(input int op, input int fn, input int alu, input int dst,
                                 input int src, input int mr, input int mw, input int m2r,
                                 input int wr, input int br);
        info_t r;
        r.op = 6'(op); r.fn = 6'(fn); r.alu = 4'(alu); r.dst = 2'(dst);
        r.src = 1'(src); r.mr = 1'(mr); r.mw = 1'(mw); r.m2r = 2'(m2r);
        r.wr = 1'(wr); r.br = 1'(br);
        return r;
    endfunction

    function automatic info_t info_of(input kind_e k);
        case (k)
            K_ADD:   return mk('h00, 'h20, 0, 1, 0, 0, 0, 0, 1, 0);
            K_ADDU:  return mk('h00, 'h21, 0, 1, 0, 0, 0, 0, 1, 0);
            K_SUB:   return mk('h00, 'h22, 1, 1, 0, 0, 0, 0, 1, 0);
            K_SUBU:  return mk('h00, 'h23, 1, 1, 0, 0, 0, 0, 1, 0);
            K_AND:   return mk('h00, 'h24, 2, 1, 0, 0, 0, 0, 1, 0);
            K_OR:    return mk('h00, 'h25, 3, 1, 0, 0, 0, 0, 1, 0);
            K_XOR:   return mk('h00, 'h26, 4, 1, 0, 0, 0, 0, 1, 0);
            K_NOR:   return mk('h00, 'h27, 5, 1, 0, 0, 0, 0, 1, 0);
            K_SLT:   return mk('h00, 'h2A, 6, 1, 0, 0, 0, 0, 1, 0);
            K_SLTU:  return mk('h00, 'h2B, 7, 1, 0, 0, 0, 0, 1, 0);
            K_SLL:   return mk('h00, 'h00, 8, 1, 0, 0, 0, 0, 1, 0);
            K_SRL:   return mk('h00, 'h02, 9, 1, 0, 0, 0, 0, 1, 0);
            K_SRA:   return mk('h00, 'h03, 10, 1, 0, 0, 0, 0, 1, 0);
            K_JR:    return mk('h00, 'h08, 0, 0, 0, 0, 0, 0, 0, 0);
            K_JALR:  return mk('h00, 'h09, 0, 1, 0, 0, 0, 2, 1, 0);
            K_LW:    return mk('h23, 0, 0, 0, 1, 1, 0, 1, 1, 0);
            K_SW:    return mk('h2B, 0, 0, 0, 1, 0, 1, 0, 0, 0);
            K_LUI:   return mk('h0F, 0, 11, 0, 1, 0, 0, 0, 1, 0);
            K_ADDI:  return mk('h08, 0, 0, 0, 1, 0, 0, 0, 1, 0);
            K_ADDIU: return mk('h09, 0, 0, 0, 1, 0, 0, 0, 1, 0);
            K_ANDI:  return mk('h0C, 0, 2, 0, 1, 0, 0, 0, 1, 0);
            K_ORI:   return mk('h0D, 0, 3, 0, 1, 0, 0, 0, 1, 0);
            K_SLTI:  return mk('h0A, 0, 6, 0, 1, 0, 0, 0, 1, 0);
            K_SLTIU: return mk('h0B, 0, 7, 0, 1, 0, 0, 0, 1, 0);
            K_BEQ:   return mk('h04, 0, 12, 0, 0, 0, 0, 0, 0, 1);
            K_BNE:   return mk('h05, 0, 13, 0, 0, 0, 0, 0, 0, 1);
            K_J:     return mk('h02, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            K_JAL:   return mk('h03, 0, 0, 2, 0, 0, 0, 2, 1, 0);
            default: return mk('h3F, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        endcase
    endfunction

    function automatic bit is_rtype(input kind_e k);
        return int'(k) <= int'(K_JALR);
    endfunction

    function automatic bit is_itype(input kind_e k);
        return int'(k) >= int'(K_LW) && int'(k) <= int'(K_BNE);
    endfunction

    function automatic logic [31:0] encode(input kind_e k, input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [15:0] imm, input logic [25:0] tgt);
        info_t i = info_of(k);
        if (is_rtype(k))              return {6'h00, rs, rt, rd, sh, i.fn};
        else if (k == K_J || k == K_JAL) return {i.op, tgt};
        else                          return {i.op, rs, rt, imm};
    endfunction

    function automatic idex_t decode_model(input kind_e k, input logic [31:0] instr,
                                           input logic [31:0] pc4, input logic [31:0] rsd,
                                           input logic [31:0] rtd);
        info_t i = info_of(k);
        idex_t e = '0;
        e.pc4 = pc4; e.rsd = rsd; e.rtd = rtd;
        e.rs = instr[25:21]; e.rt = instr[20:16]; e.rd = instr[15:11]; e.sh = instr[10:6];
        if (k == K_ANDI || k == K_ORI) e.imm = {16'h0000, instr[15:0]};
        else                           e.imm = {{16{instr[15]}}, instr[15:0]};
        e.conba = pc4 + e.imm * 32'd4;
        e.alu = i.alu; e.src = i.src; e.dst = i.dst; e.mr = i.mr; e.mw = i.mw;
        e.m2r = i.m2r; e.br = i.br;
        e.dest = (i.dst == 2'd0) ? e.rt : (i.dst == 2'd1) ? e.rd : 5'd31;
        e.wr = i.wr && (e.dest != 5'd0);
        e.lvl = (k == K_BAD) ? 2'd1 : is_itype(k) ? 2'd3 : 2'd2;
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic [31:0] instr, input logic [31:0] pc4, input logic alu_b,
                         input logic mrw, input logic [4:0] mrd,
                         input logic [31:0] rsd, input logic [31:0] rtd);
        IFID = {pc4, instr}; ALUOut = alu_b; MEM_RegWrite = mrw; MEM_Rd = mrd;
        rs_data = rsd; rt_data = rtd;
    endtask

    // One ID cycle: drive at the falling edge, check combinational outputs,
    // clock, then check what entered ID/EX.
    task automatic step(input kind_e k, input logic [31:0] instr, input logic [31:0] pc4,
                        input logic alu_b, input logic mrw, input logic [4:0] mrd,
                        input logic [31:0] rsd, input logic [31:0] rtd);
        idex_t nxt;
        logic [4:0] rs = instr[25:21];
        logic [4:0] rt = instr[20:16];
        bit reads_rt = is_rtype(k) || k == K_SW || k == K_BEQ || k == K_BNE;
        bit jreg = (k == K_JR || k == K_JALR);
        bit bt, lu, jh;
        logic [2:0] e_pcsrc = 3'b000;
        logic e_pcw = 1'b1, e_ifw = 1'b1, e_stall = 1'b0;
        string p = k.name();
        drive(instr, pc4, alu_b, mrw, mrd, rsd, rtd);
        #1;
        bt = m_ex.br && alu_b;
        lu = m_ex.mr && m_ex.rt != 0 && (m_ex.rt == rs || (reads_rt && m_ex.rt == rt));
        jh = jreg && rs != 0 && ((m_ex.wr && m_ex.dest == rs) || (mrw && mrd == rs));
        nxt = decode_model(k, instr, pc4, rsd, rtd);
        if (bt) begin
            e_pcsrc = 3'b001; e_stall = 1'b1; nxt = '0;
        end else if (lu || jh) begin
            e_pcw = 1'b0; e_ifw = 1'b0; nxt = '0;
        end else if (k == K_J || k == K_JAL) begin
            e_pcsrc = 3'b010; e_stall = 1'b1;
        end else if (jreg) begin
            e_pcsrc = 3'b011; e_stall = 1'b1;
        end
        check_eq({p, " PCSrc"},     64'(PCSrc),     64'(e_pcsrc));
        check_eq({p, " PCWrite"},   64'(PCWrite),   64'(e_pcw));
        check_eq({p, " IFIDWrite"}, 64'(IFIDWrite), 64'(e_ifw));
        check_eq({p, " Stall"},     64'(Stall),     64'(e_stall));
        check_eq({p, " JT"},        64'(JT),        64'(instr[25:0]));
        check_eq({p, " DatabusA"},  64'(DatabusA),  64'(rsd));
        check_eq({p, " rs_addr"},   64'(rs_addr),   64'(rs));
        check_eq({p, " rt_addr"},   64'(rt_addr),   64'(rt));
        exp_q.push_back(nxt);
        @(posedge clk);
        @(negedge clk);
        m_ex = exp_q.pop_front();
        check_bundle(p, m_ex);
    endtask

    // Shorthand for directed steps with quiet EX/MEM inputs
    task automatic step_i(input kind_e k, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                          input logic [31:0] pc4, input logic alu_b,
                          input logic mrw, input logic [4:0] mrd);
        step(k, encode(k, rs, rt, rd, 5'd0, imm, tgt), pc4, alu_b, mrw, mrd,
             32'hA000_0000 | 32'(rs), 32'hB000_0000 | 32'(rt));
    endtask

    // ---------------- sequence ----------------
    initial begin
        idex_t zero_full;
        zero_full = '0;
        zero_full.lvl = 2'd3;
        reset = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bundle("reset", zero_full);
        check_eq("reset PCSrc", 64'(PCSrc), 64'd0);
        check_eq("reset PCWrite", 64'(PCWrite), 64'd1);
        check_eq("reset IFIDWrite", 64'(IFIDWrite), 64'd1);
        check_eq("reset Stall", 64'(Stall), 64'd0);
        reset = 1'b1;
        m_ex = '0;

        // load-use: lw $2,0($1) ; add $3,$2,$4 stalls once then enters
        step_i(K_LW,  5'd1, 5'd2, 5'd0, 16'h0, 26'h0, 32'h10, 1'b0, 1'b0, 5'd0);
        step_i(K_ADD, 5'd2, 5'd4, 5'd3, 16'h0, 26'h0, 32'h14, 1'b0, 1'b0, 5'd0);
        step_i(K_ADD, 5'd2, 5'd4, 5'd3, 16'h0, 26'h0, 32'h14, 1'b0, 1'b0, 5'd0);
        check_eq("lu add regdst", 64'(ex_regdst), 64'd1);

        // beq at pc4 0x100, imm 3: taken, then not taken
        step_i(K_BEQ,  5'd1, 5'd2, 5'd0, 16'd3, 26'h0, 32'h100, 1'b0, 1'b0, 5'd0);
        check_eq("beq ConBA", 64'(ConBA), 64'h10C);
        step_i(K_ADDI, 5'd1, 5'd6, 5'd0, 16'd1, 26'h0, 32'h104, 1'b1, 1'b0, 5'd0);
        step_i(K_BEQ,  5'd1, 5'd2, 5'd0, 16'd3, 26'h0, 32'h100, 1'b0, 1'b0, 5'd0);
        step_i(K_ADDI, 5'd1, 5'd6, 5'd0, 16'd1, 26'h0, 32'h104, 1'b0, 1'b0, 5'd0);

        // jal at pc4 0x40, target 0x10
        step_i(K_JAL, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 32'h40, 1'b0, 1'b0, 5'd0);
        check_eq("jal memtoreg", 64'(ex_memtoreg), 64'd2);
        check_eq("jal pc4", 64'(ex_pc4), 64'h40);

        // addi $5 then jr $5: stall on ID/EX, stall on MEM, then jump
        step_i(K_ADDI, 5'd0, 5'd5, 5'd0, 16'd7, 26'h0, 32'h200, 1'b0, 1'b0, 5'd0);
        step_i(K_JR,   5'd5, 5'd0, 5'd0, 16'h0, 26'h0, 32'h204, 1'b0, 1'b0, 5'd0);
        step_i(K_JR,   5'd5, 5'd0, 5'd0, 16'h0, 26'h0, 32'h204, 1'b0, 1'b1, 5'd5);
        step_i(K_JR,   5'd5, 5'd0, 5'd0, 16'h0, 26'h0, 32'h204, 1'b0, 1'b0, 5'd0);

        // immediate extension and unknown opcode
        step_i(K_ANDI, 5'd1, 5'd7, 5'd0, 16'h8000, 26'h0, 32'h300, 1'b0, 1'b0, 5'd0);
        check_eq("andi imm", 64'(ex_imm), 64'h0000_8000);
        step_i(K_ADDI, 5'd1, 5'd7, 5'd0, 16'h8000, 26'h0, 32'h304, 1'b0, 1'b0, 5'd0);
        check_eq("addi imm", 64'(ex_imm), 64'hFFFF_8000);
        step_i(K_BAD,  5'd1, 5'd7, 5'd0, 16'h1234, 26'h0, 32'h308, 1'b0, 1'b0, 5'd0);

        // reset pulsed while a load-use stall is being presented
        step_i(K_LW, 5'd1, 5'd2, 5'd0, 16'h4, 26'h0, 32'h400, 1'b0, 1'b0, 5'd0);
        drive(encode(K_ADD, 5'd2, 5'd4, 5'd3, 5'd0, 16'h0, 26'h0), 32'h404, 1'b0, 1'b0, 5'd0,
              32'h1, 32'h2);
        #1;
        check_eq("midstall PCWrite", 64'(PCWrite), 64'd0);
        #1;
        reset = 1'b0;
        #1;
        check_bundle("async reset", zero_full);
        drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check_eq("rst PCWrite", 64'(PCWrite), 64'd1);
        check_eq("rst Stall", 64'(Stall), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_ex = '0;
        step_i(K_ADD, 5'd2, 5'd4, 5'd3, 16'h0, 26'h0, 32'h404, 1'b0, 1'b0, 5'd0);

        // randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            kind_e k = kind_e'($urandom_range(N_KIND - 1, 0));
            logic [31:0] instr = encode(k, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                                        5'($urandom_range(7, 0)), 5'($urandom_range(31, 0)),
                                        16'($urandom), 26'($urandom));
            if (k == K_BAD) instr[31:26] = 6'h3F;
            step(k, instr, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
